// File: rtl/core_sequencer.sv
// core_sequencer: in-order, single-issue RV32I issue sequencer.
// Accepts one instruction at a time, decodes OP / OP-IMM / LUI, reads operands, hands them to an
// external multi-cycle ALU, waits (bounded) for completion, then writes the result back.
// Any other opcode, or an ALU that never answers, parks the block in a trap state until reset.
//
// Ports
//   clk_i, reset_i                     clock, synchronous active-high reset
//   instr_valid_i/instr_ready_o/instr_i  fetch handshake and 32-bit instruction word
//   rf_rs1_addr_o/rf_rs2_addr_o        register-file read addresses
//   rf_rs1_data_i/rf_rs2_data_i        combinational register-file read data
//   alu_start_o                        one-cycle execute pulse
//   alu_instr_o/alu_op_a_o/alu_op_b_o  instruction and operands for the ALU
//   alu_done_i/alu_result_i            ALU completion strobe and result
//   rf_we_o/rf_wr_addr_o/rf_wr_data_o  register-file write port
//   busy_o                             not idle
//   illegal_o                          trapped
//   retired_count_o                    completed-instruction counter (wraps)
module core_sequencer #(
  // Max cycles after the alu_start cycle to wait for alu_done (1..255)
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  output logic [4:0]  rf_rs1_addr_o,
  output logic [4:0]  rf_rs2_addr_o,
  input  logic [31:0] rf_rs1_data_i,
  input  logic [31:0] rf_rs2_data_i,
  output logic        alu_start_o,
  output logic [31:0] alu_instr_o,
  output logic [31:0] alu_op_a_o,
  output logic [31:0] alu_op_b_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o,
  output logic        busy_o,
  output logic        illegal_o,
  output logic [31:0] retired_count_o
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [7:0] TimeoutCnt = 8'(ALU_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExecute,
    StWriteback,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid_i) begin
          instr_d = instr_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        cnt_d   = '0;
        state_d = StExecute;
        unique case (instr_q[6:0])
          OpcOp: begin
            op_a_d = rf_rs1_data_i;
            op_b_d = rf_rs2_data_i;
          end
          OpcOpImm: begin
            op_a_d = rf_rs1_data_i;
            op_b_d = {{20{instr_q[31]}}, instr_q[31:20]};
          end
          OpcLui: begin
            op_a_d = '0;
            op_b_d = {instr_q[31:12], 12'h000};
          end
          default: state_d = StTrap;
        endcase
      end
      StExecute: begin
        // cnt_q counts cycles since alu_start; a done in the start cycle (cnt_q == 0) is ignored,
        // and a done on the final allowed cycle takes priority over the timeout.
        if (cnt_q != 8'd0 && alu_done_i) begin
          result_d = alu_result_i;
          state_d  = StWriteback;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StTrap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWriteback: begin
        retired_d = retired_q + 32'd1;
        state_d   = StIdle;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  assign instr_ready_o   = (state_q == StIdle);
  assign busy_o          = (state_q != StIdle);
  assign illegal_o       = (state_q == StTrap);
  assign rf_rs1_addr_o   = instr_q[19:15];
  assign rf_rs2_addr_o   = instr_q[24:20];
  assign alu_start_o     = (state_q == StExecute) && (cnt_q == 8'd0);
  assign alu_instr_o     = instr_q;
  assign alu_op_a_o      = op_a_q;
  assign alu_op_b_o      = op_b_q;
  // Writes to x0 are dropped; the instruction still retires.
  assign rf_we_o         = (state_q == StWriteback) && (instr_q[11:7] != 5'd0);
  assign rf_wr_addr_o    = instr_q[11:7];
  assign rf_wr_data_o    = result_q;
  assign retired_count_o = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        alu_start;
  logic [31:0] alu_instr, op_a, op_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        rf_we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, illegal;
  logic [31:0] retired;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt    = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always @(negedge clk) begin
    if (rf_we) we_cnt++;
    if (alu_start) start_cnt++;
  end

  core_sequencer #(.ALU_TIMEOUT(16)) u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_i        (instr),
    .rf_rs1_addr_o  (rs1_addr),
    .rf_rs2_addr_o  (rs2_addr),
    .rf_rs1_data_i  (rs1_data),
    .rf_rs2_data_i  (rs2_data),
    .alu_start_o    (alu_start),
    .alu_instr_o    (alu_instr),
    .alu_op_a_o     (op_a),
    .alu_op_b_o     (op_b),
    .alu_done_i     (alu_done),
    .alu_result_i   (alu_result),
    .rf_we_o        (rf_we),
    .rf_wr_addr_o   (wr_addr),
    .rf_wr_data_o   (wr_data),
    .busy_o         (busy),
    .illegal_o      (illegal),
    .retired_count_o(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issue one legal instruction; ALU answers k cycles after alu_start with res.
  task automatic run_op(input string nm, input logic [31:0] ins, input int k,
                        input logic [31:0] res, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ret_exp);
    int we0;
    we0 = we_cnt;
    instr_valid = 1'b1;
    instr       = ins;
    check({nm, "_ready_idle"}, instr_ready, 1);
    step();
    instr_valid = 1'b0;
    instr       = 32'h0;
    // DECODE
    check({nm, "_dec_ready"}, instr_ready, 0);
    check({nm, "_dec_busy"}, busy, 1);
    check({nm, "_rs1"}, rs1_addr, ins[19:15]);
    check({nm, "_rs2"}, rs2_addr, ins[24:20]);
    check({nm, "_dec_start"}, alu_start, 0);
    step();
    // EXECUTE, alu_start cycle; a done here must be ignored
    check({nm, "_start"}, alu_start, 1);
    check({nm, "_alu_instr"}, alu_instr, ins);
    check({nm, "_op_a"}, op_a, ea);
    check({nm, "_op_b"}, op_b, eb);
    alu_done   = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    for (int i = 1; i <= k; i++) begin
      step();
      if (i == 1) check({nm, "_start_pulse"}, alu_start, 0);
      alu_done   = (i == k);
      alu_result = (i == k) ? res : 32'hDEAD_BEEF;
    end
    step();
    alu_done   = 1'b0;
    alu_result = 32'h0;
    // WRITEBACK
    check({nm, "_we"}, rf_we, (ins[11:7] != 5'd0) ? 1 : 0);
    check({nm, "_wr_addr"}, wr_addr, ins[11:7]);
    check({nm, "_wr_data"}, wr_data, res);
    check({nm, "_wb_ready"}, instr_ready, 0);
    step();
    check({nm, "_we_pulse"}, rf_we, 0);
    check({nm, "_ready_after"}, instr_ready, 1);
    check({nm, "_retired"}, retired, ret_exp);
    check({nm, "_we_count"}, we_cnt - we0, (ins[11:7] != 5'd0) ? 1 : 0);
  endtask

  initial begin
    int s0, w0;
    foreach (rf[i]) rf[i] = 32'h0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    instr_valid = 1'b1;  // held during reset, must not be accepted
    instr       = 32'h002081B3;
    alu_done    = 1'b0;
    alu_result  = 32'h0;
    do_reset();
    instr_valid = 1'b0;

    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    check("rst_start", alu_start, 0);
    check("rst_we", rf_we, 0);
    check("rst_retired", retired, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rs1", rs1_addr, 0);
    step();
    check("rst_valid_ignored", busy, 0);

    run_op("add", 32'h002081B3, 2, 32'd12, 32'd5, 32'd7, 32'd1);
    run_op("addi", 32'hFFF00093, 1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd2);
    run_op("lui", 32'h123452B7, 3, 32'h1234_5000, 32'h0, 32'h1234_5000, 32'd3);
    run_op("addx0", 32'h00208033, 2, 32'd12, 32'd5, 32'd7, 32'd4);
    // Done on exactly the final allowed cycle wins over the timeout
    run_op("edge16", 32'h002081B3, 16, 32'd12, 32'd5, 32'd7, 32'd5);

    // Timeout: done withheld
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    step();
    instr_valid = 1'b0;
    step();
    check("to_start", alu_start, 1);
    for (int i = 1; i <= 16; i++) step();
    check("to_c16_illegal", illegal, 0);
    check("to_c16_busy", busy, 1);
    step();
    check("to_trap", illegal, 1);
    check("to_ready", instr_ready, 0);
    check("to_retired", retired, 5);
    do_reset();
    check("to_reset_illegal", illegal, 0);
    check("to_reset_retired", retired, 0);

    // ECALL traps after DECODE
    s0 = start_cnt;
    instr_valid = 1'b1;
    instr       = 32'h00000073;
    step();
    instr_valid = 1'b0;
    check("ecall_dec_illegal", illegal, 0);
    step();
    check("ecall_illegal", illegal, 1);
    check("ecall_busy", busy, 1);
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("ecall_ready_stuck", instr_ready, 0);
    check("ecall_still_trap", illegal, 1);
    check("ecall_no_start", start_cnt - s0, 0);
    instr_valid = 1'b0;
    do_reset();
    check("ecall_reset_ready", instr_ready, 1);

    // Reset during EXECUTE
    w0 = we_cnt;
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    step();
    instr_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", instr_ready, 1);
    alu_done   = 1'b1;
    alu_result = 32'd99;
    step();
    alu_done   = 1'b0;
    check("late_done_busy", busy, 0);
    step();
    check("midrst_no_we", we_cnt - w0, 0);
    check("midrst_retired", retired, 0);
    run_op("after_rst", 32'h002081B3, 1, 32'd12, 32'd5, 32'd7, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter ALU_TIMEOUT, default 16, meaning max cycles after alu_start that the block waits for alu_done before trapping (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 instr_valid  input  1  upstream (fetch) instruction valid.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 instr  input  32  RV32I instruction word, sampled on handshake.
REQ-007 rf_rs1_addr / rf_rs2_addr  output  5 each  register-file read addresses.
REQ-008 rf_rs1_data / rf_rs2_data  input  32 each  combinational read data for the addresses above.
REQ-009 alu_start  output  1  one-cycle execute pulse to ALU.
REQ-010 alu_instr / alu_op_a / alu_op_b  output  32 each  instruction and operands presented to ALU, stable from alu_start until alu_done.
REQ-011 alu_done / alu_result  input  1 / 32  ALU completion strobe and result.
REQ-012 rf_we / rf_wr_addr / rf_wr_data  output  1 / 5 / 32  register-file write port.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 illegal  output  1  high while in TRAP.
REQ-015 retired_count  output  32  count of completed instructions.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, EXECUTE, WRITEBACK, TRAP; TRAP exits only via reset.
REQ-017 IDLE: instr_ready=1; on instr_valid && instr_ready, instr captured into an internal register, next state DECODE; instr_ready=0 in all other states.
REQ-018 DECODE (exactly 1 cycle): rf_rs1_addr=instr[19:15], rf_rs2_addr=instr[24:20]; opcode instr[6:0] legal only for 0110011 (OP), 0010011 (OP-IMM), 0110111 (LUI); illegal opcode -> TRAP, legal -> EXECUTE.
REQ-019 Operands latched at end of DECODE: OP: a=rs1_data, b=rs2_data; OP-IMM: a=rs1_data, b=sign-extended instr[31:20]; LUI: a=0, b={instr[31:12],12'h000}.
REQ-020 EXECUTE: alu_start=1 in the first EXECUTE cycle only; alu_done sampled from the following cycle onward; on alu_done, alu_result latched, next state WRITEBACK.
REQ-021 Timeout counter cleared on entry to EXECUTE; if alu_done not seen within ALU_TIMEOUT cycles after the alu_start cycle -> TRAP; alu_done in the same cycle as the final count wins (no trap).
REQ-022 alu_done in IDLE, DECODE, WRITEBACK, TRAP, or in the alu_start cycle SHALL be ignored.
REQ-023 WRITEBACK (exactly 1 cycle): rf_wr_addr=instr[11:7], rf_wr_data=latched result; rf_we=1 unless rd==0 (write suppressed, instruction still retires); retired_count increments by 1, wraps 0xFFFFFFFF -> 0; next state IDLE.
REQ-024 Latency: handshake in cycle N -> DECODE N+1 -> alu_start N+2 -> alu_done at N+2+k (k>=1) -> rf_we at N+3+k -> instr_ready at N+4+k.
REQ-025 rf_we, alu_start are single-cycle pulses; no output is X after reset.

Reset
REQ-026 Reset high at a rising edge SHALL force IDLE and clear: instr_ready->1 (after reset deasserts), busy=0, illegal=0, alu_start=0, rf_we=0, retired_count=0, all address/data/operand outputs=0.
REQ-027 Reset mid-operation (any state, incl. TRAP) SHALL discard the captured instruction with no register-file write and no retire.
REQ-028 An instr_valid held high during the reset cycle SHALL NOT be accepted in that cycle.

Verification
REQ-029 ADD x3,x1,x2 (0x002081B3), x1=5, x2=7, ALU done 2 cycles after start with 12 -> rs addrs 1/2, op_a=5, op_b=7, one rf_we pulse addr 3 data 12, retired_count=1.
REQ-030 ADDI x1,x0,-1 (0xFFF00093) -> op_a=0, op_b=0xFFFFFFFF; LUI x5,0x12345 (0x123452B7) -> op_a=0, op_b=0x12345000.
REQ-031 ADD x0,x1,x2 (0x00208033) -> rf_we never asserted, retired_count increments.
REQ-032 ECALL (0x00000073) -> TRAP after DECODE, illegal=1, no alu_start, instr_ready stays 0 until reset.
REQ-033 alu_done withheld with ALU_TIMEOUT=16 -> TRAP on cycle 16 after alu_start; done on exactly cycle 16 -> WRITEBACK, no trap.
REQ-034 Reset asserted during EXECUTE -> IDLE next cycle, no rf_we, retired_count=0, a late alu_done ignored; following instruction completes normally.
